// File: rtl/gun_ctrl_pkg.sv
// Shared types and default geometry for the light-gun crosshair controller.
package gun_ctrl_pkg;

  typedef enum logic {IDLE, HOLD} axis_state_t;
  typedef enum logic {DIR_NEG, DIR_POS} axis_dir_t;

  localparam int GUN_POS_W   = 6;
  localparam int GUN_POS_MAX = 63;

endpackage

// File: rtl/gun_axis.sv
// One crosshair axis: press/auto-repeat FSM, repeat divider and saturating step.
// GUN_ACCEL_EN adds a repeat counter that doubles the step after ACCEL_HOLD repeats.
module gun_axis
  import gun_ctrl_pkg::*;
#(
  parameter int POS_W   = GUN_POS_W,
  parameter int POS_MAX = GUN_POS_MAX,
  parameter int CENTER  = 32,
  parameter int DIV_MAX = 3
`ifdef GUN_ACCEL_EN
  ,
  parameter int ACCEL_HOLD = 8
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_ev,
  input  logic             recenter,
  input  logic             neg,
  input  logic             pos,
  output logic [POS_W-1:0] position,
  output logic             changed,
  output axis_state_t      state
);

  localparam int                DIV_W    = $clog2(DIV_MAX);
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(DIV_MAX - 1);
  localparam logic [POS_W:0]    MAX_WIDE = (POS_W + 1)'(POS_MAX);
  localparam logic [POS_W-1:0]  CENTER_P = POS_W'(CENTER);

  axis_dir_t        dir;
  axis_dir_t        req_dir;
  logic [DIV_W-1:0] div;
  logic             one_dir;
  logic             fresh;
  logic             rpt;
  logic             do_step;
  logic [POS_W:0]   amt;
  logic [POS_W:0]   wide;
  logic [POS_W:0]   stepped;
  logic [POS_W-1:0] pos_nxt;

`ifdef GUN_ACCEL_EN
  localparam int               REP_W    = $clog2(ACCEL_HOLD + 1);
  localparam logic [REP_W-1:0] REP_FULL = REP_W'(ACCEL_HOLD);
  logic [REP_W-1:0] rep_cnt;
`endif

  always_comb begin
    one_dir = neg ^ pos;
    req_dir = pos ? DIR_POS : DIR_NEG;
    // A reversal while holding behaves exactly like a first press.
    fresh   = one_dir && ((state == IDLE) || (dir != req_dir));
    rpt     = one_dir && (state == HOLD) && (dir == req_dir) && (div == DIV_LAST);
    do_step = tick_ev && (fresh || rpt);
    amt     = (POS_W + 1)'(1);
`ifdef GUN_ACCEL_EN
    if (rpt && (rep_cnt == REP_FULL)) amt = (POS_W + 1)'(2);
`endif
    wide = {1'b0, position};
    if (req_dir == DIR_POS) stepped = ((wide + amt) > MAX_WIDE) ? MAX_WIDE : (wide + amt);
    else                    stepped = (wide < amt) ? '0 : (wide - amt);
    pos_nxt = position;
    if (recenter)     pos_nxt = CENTER_P;
    else if (do_step) pos_nxt = stepped[POS_W-1:0];
    changed = (pos_nxt != position);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      position <= CENTER_P;
      state    <= IDLE;
      dir      <= DIR_NEG;
      div      <= '0;
`ifdef GUN_ACCEL_EN
      rep_cnt  <= '0;
`endif
    end else begin
      position <= pos_nxt;
      if (recenter) begin
        state   <= IDLE;
        div     <= '0;
`ifdef GUN_ACCEL_EN
        rep_cnt <= '0;
`endif
      end else if (tick_ev) begin
        if (!one_dir) begin
          state   <= IDLE;
          div     <= '0;
`ifdef GUN_ACCEL_EN
          rep_cnt <= '0;
`endif
        end else if (fresh) begin
          state   <= HOLD;
          dir     <= req_dir;
          div     <= '0;
`ifdef GUN_ACCEL_EN
          rep_cnt <= '0;
`endif
        end else if (rpt) begin
          div     <= '0;
`ifdef GUN_ACCEL_EN
          if (rep_cnt != REP_FULL) rep_cnt <= rep_cnt + 1'b1;
`endif
        end else begin
          div <= div + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/gun_position_ctrl.sv
// Joystick-to-gun-coordinate wrapper: 4 ms tick edge detect, two axes, update pulse.
// Optional build macro GUN_ACCEL_EN enables held-direction acceleration.
module gun_position_ctrl
  import gun_ctrl_pkg::*;
#(
  parameter int POS_W    = GUN_POS_W,
  parameter int POS_MAX  = GUN_POS_MAX,
  parameter int H_CENTER = 32,
  parameter int V_CENTER = 32,
  parameter int DIV_MAX  = 3
`ifdef GUN_ACCEL_EN
  ,
  parameter int ACCEL_HOLD = 8
`endif
) (
  input  logic             clock_12,
  input  logic             reset_n,
  input  logic             tick_4ms,
  input  logic             joy_left,
  input  logic             joy_right,
  input  logic             joy_up,
  input  logic             joy_down,
  input  logic             recenter,
  output logic [POS_W-1:0] gun_h,
  output logic [POS_W-1:0] gun_v,
  output logic             gun_update,
  output logic             moving
);

  logic        tick_r;
  logic        tick_ev;
  logic        h_changed;
  logic        v_changed;
  axis_state_t h_state;
  axis_state_t v_state;

  assign tick_ev = tick_4ms & ~tick_r;

  always_ff @(posedge clock_12 or negedge reset_n) begin
    if (!reset_n) begin
      tick_r     <= 1'b0;
      gun_update <= 1'b0;
    end else begin
      tick_r     <= tick_4ms;
      // Lines up with the register load of the new coordinate in the axes.
      gun_update <= h_changed | v_changed;
    end
  end

  gun_axis #(
    .POS_W(POS_W), .POS_MAX(POS_MAX), .CENTER(H_CENTER), .DIV_MAX(DIV_MAX)
`ifdef GUN_ACCEL_EN
    , .ACCEL_HOLD(ACCEL_HOLD)
`endif
  ) u_axis_h (
    .clk(clock_12), .rst_n(reset_n), .tick_ev(tick_ev), .recenter(recenter),
    .neg(joy_left), .pos(joy_right),
    .position(gun_h), .changed(h_changed), .state(h_state)
  );

  gun_axis #(
    .POS_W(POS_W), .POS_MAX(POS_MAX), .CENTER(V_CENTER), .DIV_MAX(DIV_MAX)
`ifdef GUN_ACCEL_EN
    , .ACCEL_HOLD(ACCEL_HOLD)
`endif
  ) u_axis_v (
    .clk(clock_12), .rst_n(reset_n), .tick_ev(tick_ev), .recenter(recenter),
    .neg(joy_up), .pos(joy_down),
    .position(gun_v), .changed(v_changed), .state(v_state)
  );

  assign moving = (h_state == HOLD) || (v_state == HOLD);

endmodule

// File: tb/tb_gun_position_ctrl.sv
// Randomized bench for gun_position_ctrl against a hold-count reference model.
module tb_gun_position_ctrl;

  localparam int POS_MAX  = 63;
  localparam int H_CENTER = 32;
  localparam int V_CENTER = 32;
  localparam int DIV_MAX  = 3;
`ifdef GUN_ACCEL_EN
  localparam int ACCEL_HOLD = 8;
`endif

  // clock / reset
  logic       clock_12 = 1'b0;
  logic       reset_n;
  logic       tick_4ms;
  logic       joy_left, joy_right, joy_up, joy_down;
  logic       recenter;
  logic [5:0] gun_h, gun_v;
  logic       gun_update;
  logic       moving;

  always #5 clock_12 = ~clock_12;

  gun_position_ctrl dut (
    .clock_12(clock_12), .reset_n(reset_n), .tick_4ms(tick_4ms),
    .joy_left(joy_left), .joy_right(joy_right), .joy_up(joy_up), .joy_down(joy_down),
    .recenter(recenter),
    .gun_h(gun_h), .gun_v(gun_v), .gun_update(gun_update), .moving(moving)
  );

  // reference model: position plus number of consecutive ticks one direction was held
  int m_h, m_v;
  int held_h, held_v;
  bit dir_h, dir_v;
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int clamp(input int p);
    if (p < 0) return 0;
    if (p > POS_MAX) return POS_MAX;
    return p;
  endfunction

  task automatic model_axis(input bit n, input bit p, inout int pos, inout int held, inout bit dir);
    int amt;
    if (n ^ p) begin
      if (held > 0 && dir == p) held++;
      else held = 1;
      dir = p;
      // Steps land on hold ticks 1, 1+DIV_MAX, 1+2*DIV_MAX, ...
      if ((held - 1) % DIV_MAX == 0) begin
        amt = 1;
`ifdef GUN_ACCEL_EN
        if ((held - 1) / DIV_MAX > ACCEL_HOLD) amt = 2;
`endif
        pos = clamp(pos + (p ? amt : -amt));
      end
    end else begin
      held = 0;
    end
  endtask

  task automatic model_reset();
    m_h = H_CENTER; m_v = V_CENTER;
    held_h = 0; held_v = 0;
    dir_h = 0; dir_v = 0;
  endtask

  task automatic check_outputs(input string tag, input bit exp_upd);
    check({tag, ".gun_h"}, int'(gun_h), m_h);
    check({tag, ".gun_v"}, int'(gun_v), m_v);
    check({tag, ".gun_update"}, int'(gun_update), int'(exp_upd));
    check({tag, ".moving"}, int'(moving), int'(held_h > 0 || held_v > 0));
  endtask

  // driver: one 4 ms tick with the given directions, optional recenter on the same cycle
  task automatic do_tick(input bit l, input bit r, input bit u, input bit d, input bit rc);
    int oh, ov;
    oh = m_h; ov = m_v;
    @(negedge clock_12);
    joy_left = l; joy_right = r; joy_up = u; joy_down = d;
    recenter = rc; tick_4ms = 1'b1;
    if (rc) begin
      m_h = H_CENTER; m_v = V_CENTER; held_h = 0; held_v = 0;
    end else begin
      model_axis(l, r, m_h, held_h, dir_h);
      model_axis(u, d, m_v, held_v, dir_v);
    end
    @(negedge clock_12);
    recenter = 1'b0;
    check_outputs("tick", (m_h != oh) || (m_v != ov));
    // Tick level stays high and the stick wanders: nothing may change until the next edge.
    repeat ($urandom_range(1, 3)) begin
      {joy_left, joy_right, joy_up, joy_down} = 4'($urandom_range(0, 15));
      @(negedge clock_12);
      check("between.gun_update", int'(gun_update), 0);
      check("between.gun_h", int'(gun_h), m_h);
    end
    tick_4ms = 1'b0;
    repeat ($urandom_range(1, 2)) @(negedge clock_12);
  endtask

  task automatic do_recenter();
    int oh, ov;
    oh = m_h; ov = m_v;
    @(negedge clock_12);
    recenter = 1'b1;
    m_h = H_CENTER; m_v = V_CENTER; held_h = 0; held_v = 0;
    @(negedge clock_12);
    recenter = 1'b0;
    check_outputs("recenter", (m_h != oh) || (m_v != ov));
  endtask

  task automatic do_reset();
    @(negedge clock_12);
    reset_n = 1'b0;
    tick_4ms = 1'b0;
    model_reset();
    #1;
    check_outputs("reset", 1'b0);
    @(negedge clock_12);
    reset_n = 1'b1;
  endtask

  bit [3:0] pat;

  initial begin
    reset_n = 1'b0; tick_4ms = 1'b0; recenter = 1'b0;
    joy_left = 0; joy_right = 0; joy_up = 0; joy_down = 0;
    model_reset();
    repeat (3) @(negedge clock_12);
    check_outputs("por", 1'b0);
    reset_n = 1'b1;

    // idle ticks keep the centre
    repeat (20) do_tick(0, 0, 0, 0, 0);
    check("idle_h", int'(gun_h), 32);

    // held right: steps on ticks 1,4,7,10
    repeat (10) do_tick(0, 1, 0, 0, 0);
    check("hold_right_h", int'(gun_h), 36);
    check("hold_right_v", int'(gun_v), 32);

    // drive into both clamps and keep pushing
    repeat (100) do_tick(0, 1, 0, 0, 0);
    check("clamp_hi", int'(gun_h), 63);
    repeat (6) do_tick(0, 1, 0, 0, 0);
    repeat (200) do_tick(1, 0, 0, 0, 0);
    check("clamp_lo", int'(gun_h), 0);

    // reversal gives an immediate step
    do_tick(0, 0, 0, 0, 0);
    do_recenter();
    do_tick(0, 0, 1, 0, 0);
    do_tick(0, 0, 1, 0, 0);
    do_tick(0, 0, 0, 1, 0);
    check("reversal_v", int'(gun_v), 32);

    // both directions together cancel
    repeat (5) do_tick(1, 1, 0, 0, 0);
    check("both_h", int'(gun_h), 32);

    // recenter wins over a same-cycle tick
    do_tick(0, 0, 0, 0, 0);
    repeat (22) do_tick(0, 0, 0, 1, 0);
    check("pre_recenter_v", int'(gun_v), 40);
    do_tick(0, 0, 0, 1, 1);
    check("recenter_tick_v", int'(gun_v), 32);

    // reset in the middle of a hold, then a fresh press
    repeat (5) do_tick(0, 1, 0, 0, 0);
    do_reset();
    do_tick(0, 1, 0, 0, 0);
    check("post_reset_h", int'(gun_h), 33);

    // random stick activity with occasional recenters
    pat = 4'b0000;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 5) == 0) pat = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 40) == 0) do_recenter();
      do_tick(pat[0], pat[1], pat[2], pat[3], $urandom_range(0, 30) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
